// File: rtl/charge_integ.sv
// charge_integ: bunch-charge integrator.
// Sums NUM_SMPLS_INTEG ADC samples starting at each bunch strobe, scales the
// sum by 2**GAIN_SHIFT, saturates to 21-bit signed and presents it as the
// charge word for the feedback multiplier.
// Optional build macro CHARGE_PED_SUB_EN: subtract ped_in from every sample
// before accumulation (15-bit signed difference, accumulator one bit wider).
module charge_integ #(
  parameter int NUM_SMPLS_INTEG = 4,
  parameter int GAIN_SHIFT      = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [13:0] adc_in,
  input  logic signed [13:0] ped_in,
  input  logic               store_strb,
  input  logic               bunch_strb,
  output logic signed [20:0] charge_out,
  output logic               charge_valid,
  output logic               busy
);

`ifdef CHARGE_PED_SUB_EN
  localparam int SW = 15;
`else
  localparam int SW = 14;
`endif
  localparam int CW = $clog2(NUM_SMPLS_INTEG) + 1;
  localparam int AW = SW + $clog2(NUM_SMPLS_INTEG) + 1;
  // Scaling width always exceeds both the shifted sum and the 21-bit range,
  // so the saturation compare sees the true value.
  localparam int EW = (((AW + GAIN_SHIFT) > 22) ? (AW + GAIN_SHIFT) : 22) + 1;
  localparam logic signed [EW-1:0] SAT_HI = EW'(1048575);
  localparam logic signed [EW-1:0] SAT_LO = EW'(-1048576);
  localparam logic [CW-1:0]        LAST_CNT = CW'(NUM_SMPLS_INTEG - 1);
  localparam logic                 SINGLE = (NUM_SMPLS_INTEG == 1);

  typedef enum logic {IDLE, INTEG} state_t;

  state_t                state, state_nxt;
  logic signed [AW-1:0]  acc;
  logic [CW-1:0]         cnt;
  logic signed [SW-1:0]  sample;
  logic signed [AW-1:0]  sample_ext;
  logic signed [AW-1:0]  acc_nxt;
  logic signed [EW-1:0]  sum_ext;
  logic signed [EW-1:0]  scaled;
  logic signed [20:0]    sat_val;
  logic                  last_smp;
  logic                  done;

  // Sample conditioning: optional pedestal subtraction, then sign extension
`ifdef CHARGE_PED_SUB_EN
  always_comb begin
    sample = {adc_in[13], adc_in} - {ped_in[13], ped_in};
  end
`else
  logic unused_ped;
  always_comb begin
    sample     = adc_in;
    unused_ped = ^ped_in;
  end
`endif

  // Running sum, completion detect and scaled/saturated result
  always_comb begin
    sample_ext = {{(AW-SW){sample[SW-1]}}, sample};
    acc_nxt    = (bunch_strb || state == IDLE) ? sample_ext : acc + sample_ext;
    last_smp   = (cnt == LAST_CNT);
    done       = store_strb &&
                 (bunch_strb ? SINGLE : (state == INTEG && last_smp));
    sum_ext    = {{(EW-AW){acc_nxt[AW-1]}}, acc_nxt};
    scaled     = sum_ext <<< GAIN_SHIFT;
    if (scaled > SAT_HI)      sat_val = SAT_HI[20:0];
    else if (scaled < SAT_LO) sat_val = SAT_LO[20:0];
    else                      sat_val = scaled[20:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: bunch strobe (re)starts, last sample or window drop ends
  always_comb begin
    state_nxt = state;
    if (!store_strb)                     state_nxt = IDLE;
    else if (bunch_strb)                 state_nxt = SINGLE ? IDLE : INTEG;
    else if (state == INTEG && last_smp) state_nxt = IDLE;
  end

  // FSM outputs
  always_comb begin
    busy = (state == INTEG);
  end

  // Accumulator, sample counter and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      cnt          <= '0;
      charge_out   <= '0;
      charge_valid <= 1'b0;
    end else if (!store_strb) begin
      acc          <= '0;
      cnt          <= '0;
      charge_out   <= '0;
      charge_valid <= 1'b0;
    end else begin
      charge_valid <= done;
      if (done) charge_out <= sat_val;
      if (bunch_strb) begin
        acc <= SINGLE ? '0 : sample_ext;
        cnt <= SINGLE ? '0 : CW'(1);
      end else if (state == INTEG) begin
        if (last_smp) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
